nobl_arbiter: RTL and testbench

//  Two-client arbiter in front of the NoBL/ZBT SRAM controller: one read or write per clk.

---
 rtl/nobl_arbiter.sv | 82 ++++++++
 tb/tb_nobl_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/nobl_arbiter.sv
// nobl_arbiter: two-client round-robin arbiter with bounded bursts in front of a NoBL/ZBT SRAM controller,
// routing returned read words back to their issuer through a fixed-latency tag pipe.
module nobl_arbiter #(
    parameter int WIDTH     = 18,
    parameter int DEPTH     = 19,
    parameter int READ_LAT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c0_req,
    input  logic             c0_we,
    input  logic [DEPTH-1:0] c0_addr,
    input  logic [WIDTH-1:0] c0_wdata,
    output logic             c0_ack,
    output logic [WIDTH-1:0] c0_rdata,
    output logic             c0_rvalid,
    input  logic             c1_req,
    input  logic             c1_we,
    input  logic [DEPTH-1:0] c1_addr,
    input  logic [WIDTH-1:0] c1_wdata,
    output logic             c1_ack,
    output logic [WIDTH-1:0] c1_rdata,
    output logic             c1_rvalid,
    output logic [DEPTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_write_data,
    output logic             mem_write,
    output logic             mem_read,
    input  logic [WIDTH-1:0] mem_read_data,
    input  logic             mem_read_data_valid,
    output logic             err
);
    localparam int CW = $clog2(MAX_BURST + 1);
    logic                last, issue_client, grant, win1, keep, sel_we, tail_v, tail_c;
    logic [CW-1:0]       cnt;
    logic [READ_LAT-1:0] tag_v, tag_c;
    // cnt is nonzero only when the previous cycle was a grant, which always went to last
    always_comb begin
        keep   = (cnt != '0) && (cnt < CW'(MAX_BURST));
        win1   = c1_req & (~c0_req | (keep ? last : ~last));
        grant  = (c0_req | c1_req) & ~rst;
        sel_we = win1 ? c1_we : c0_we;
        c0_ack = grant & ~win1;
        c1_ack = grant & win1;
    end
    assign tail_v    = tag_v[READ_LAT-1];
    assign tail_c    = tag_c[READ_LAT-1];
    assign c0_rdata  = mem_read_data;
    assign c1_rdata  = mem_read_data;
    assign c0_rvalid = mem_read_data_valid & tail_v & ~tail_c & ~rst;
    assign c1_rvalid = mem_read_data_valid & tail_v & tail_c & ~rst;
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            issue_client   <= 1'b0;
            last           <= 1'b1;
            cnt            <= '0;
            tag_v          <= '0;
            tag_c          <= '0;
            err            <= 1'b0;
        end else begin
            mem_write    <= grant & sel_we;
            mem_read     <= grant & ~sel_we;
            issue_client <= win1;
            if (grant) begin
                mem_address    <= win1 ? c1_addr : c0_addr;
                mem_write_data <= win1 ? c1_wdata : c0_wdata;
                last           <= win1;
                cnt            <= (win1 == last && cnt != '0) ?
                                  ((cnt == CW'(MAX_BURST)) ? cnt : cnt + 1'b1) : CW'(1);
            end else begin
                cnt <= '0;
            end
            tag_v <= (tag_v << 1) | READ_LAT'(mem_read);
            tag_c <= (tag_c << 1) | READ_LAT'(issue_client);
            err   <= err | (mem_read_data_valid ^ tail_v);
        end
    end
endmodule

// File: tb/tb_nobl_arbiter.sv
// tb_nobl_arbiter: directed and random stimulus against a transaction-level arbitration/memory model.
module tb_nobl_arbiter;
    localparam int W = 18, D = 19, L = 4, MB = 8;
    typedef struct {int c; logic [W-1:0] d; int due;} rd_t;
    logic clk = 0, rst = 0, force_v = 0;
    logic c0_req = 0, c0_we = 0, c1_req = 0, c1_we = 0;
    logic [D-1:0] c0_addr = '0, c1_addr = '0;
    logic [W-1:0] c0_wdata = '0, c1_wdata = '0;
    logic c0_ack, c1_ack, c0_rvalid, c1_rvalid, mem_write, mem_read, mem_read_data_valid, err;
    logic [W-1:0] c0_rdata, c1_rdata, mem_write_data, mem_read_data;
    logic [D-1:0] mem_address;
    logic [W-1:0] mem [256];
    logic         dl_v [L];
    logic [W-1:0] dl_d [L];
    logic [W-1:0] model_mem [256];
    rd_t q[$];
    int nerr = 0, nchk = 0, cyc = 0, m_last = 1, m_prev = -1, m_run = 0, m_w = -1;
    logic exp_err = 0, due_now = 0;
    int seq [24];
    bit pend0, pend1;

    always #5 clk = ~clk;

    nobl_arbiter #(.WIDTH(W), .DEPTH(D), .READ_LAT(L), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_ack(c0_ack), .c0_rdata(c0_rdata), .c0_rvalid(c0_rvalid),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_ack(c1_ack), .c1_rdata(c1_rdata), .c1_rvalid(c1_rvalid),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_read_data(mem_read_data), .mem_read_data_valid(mem_read_data_valid), .err(err));

    // SRAM controller stand-in: fixed READ_LAT return latency, cleared by the shared reset
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] = '0;
            for (int i = 0; i < L; i++) dl_v[i] <= 1'b0;
        end else begin
            dl_v[0] <= mem_read;
            dl_d[0] <= mem[mem_address[7:0]];
            for (int i = 1; i < L; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_d[i] <= dl_d[i-1];
            end
            if (mem_write) mem[mem_address[7:0]] = mem_write_data;
        end
    end
    assign mem_read_data_valid = dl_v[L-1] | force_v;
    assign mem_read_data       = dl_d[L-1];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set0(logic r, logic we, logic [D-1:0] a, logic [W-1:0] d);
        c0_req = r; c0_we = we; c0_addr = a; c0_wdata = d;
    endtask

    task automatic set1(logic r, logic we, logic [D-1:0] a, logic [W-1:0] d);
        c1_req = r; c1_we = we; c1_addr = a; c1_wdata = d;
    endtask

    task automatic step();
        int w;
        logic ewe, e0, e1;
        logic [D-1:0] ea;
        logic [W-1:0] ed;
        #1;
        w = -1;
        if (c0_req && c1_req) w = (m_prev == m_last && m_run < MB) ? m_last : 1 - m_last;
        else if (c0_req) w = 0;
        else if (c1_req) w = 1;
        chk("ack0", c0_ack, w == 0);
        chk("ack1", c1_ack, w == 1);
        ewe = (w == 1) ? c1_we : c0_we;
        ea  = (w == 1) ? c1_addr : c0_addr;
        ed  = (w == 1) ? c1_wdata : c0_wdata;
        if (force_v && !due_now) exp_err = 1'b1;
        if (w >= 0) begin
            m_run  = (m_prev == w) ? ((m_run < MB) ? m_run + 1 : MB) : 1;
            m_prev = w;
            m_last = w;
            if (ewe) model_mem[ea[7:0]] = ed;
            else q.push_back('{w, model_mem[ea[7:0]], cyc + 1 + L});
        end else begin
            m_prev = -1;
            m_run  = 0;
        end
        m_w = w;
        @(posedge clk);
        cyc++;
        #1;
        chk("mem_write", mem_write, w >= 0 && ewe);
        chk("mem_read", mem_read, w >= 0 && !ewe);
        if (w >= 0) chk("mem_address", mem_address, ea);
        if (w >= 0 && ewe) chk("mem_write_data", mem_write_data, ed);
        e0 = q.size() > 0 && q[0].due == cyc && q[0].c == 0;
        e1 = q.size() > 0 && q[0].due == cyc && q[0].c == 1;
        chk("rvalid0", c0_rvalid, e0);
        chk("rvalid1", c1_rvalid, e1);
        if (e0) chk("rdata0", c0_rdata, q[0].d);
        if (e1) chk("rdata1", c1_rdata, q[0].d);
        due_now = e0 | e1;
        if (due_now) void'(q.pop_front());
        chk("err", err, exp_err);
        @(negedge clk);
    endtask

    task automatic rst_step();
        rst = 1;
        set0(0, 0, '0, '0);
        set1(0, 0, '0, '0);
        #1;
        chk("rst_ack0", c0_ack, 0);
        chk("rst_ack1", c1_ack, 0);
        @(posedge clk);
        cyc++;
        #1;
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_write_data", mem_write_data, 0);
        chk("rst_err", err, 0);
        chk("rst_rvalid", {c0_rvalid, c1_rvalid}, 0);
        q.delete();
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        m_last = 1; m_prev = -1; m_run = 0; exp_err = 0; due_now = 0;
        rst = 0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        rst_step();
        rst_step();
        // Continuous contention straight out of reset: c0 first, bursts of MB
        for (int i = 0; i < 24; i++) begin
            set0(1, 1, D'(i), W'(i));
            set1(1, 1, D'(i + 32), W'(i + 100));
            step();
            seq[i] = m_w;
        end
        for (int i = 0; i < 24; i++) chk("burst_order", seq[i], (i / MB) % 2);
        set0(0, 0, '0, '0);
        set1(0, 0, '0, '0);
        step();
        // Write then read back on c0
        set0(1, 1, 19'h00010, 18'h2A5A5);
        step();
        set0(0, 0, '0, '0);
        repeat (6) step();
        set0(1, 0, 19'h00010, '0);
        step();
        set0(0, 0, '0, '0);
        repeat (4) step();
        chk("t1_rvalid0", c0_rvalid, 1);
        chk("t1_rdata0", c0_rdata, 18'h2A5A5);
        step();
        // Back-to-back write/read/write
        set0(1, 1, 19'h20, 18'h11111); step();
        set0(0, 0, '0, '0); set1(1, 0, 19'h10, '0); step();
        set1(0, 0, '0, '0); set0(1, 1, 19'h21, 18'h22222); step();
        set0(0, 0, '0, '0);
        repeat (6) step();
        // Interleaved reads c0, c1, c0
        set0(1, 0, 19'h20, '0); step();
        set0(0, 0, '0, '0); set1(1, 0, 19'h21, '0); step();
        set1(0, 0, '0, '0); set0(1, 0, 19'h10, '0); step();
        set0(0, 0, '0, '0);
        repeat (6) step();
        // last=0 after a c0 grant and idle: c1 must win contention
        set0(1, 1, 19'h30, 18'h33333); step();
        set0(0, 0, '0, '0); step();
        set0(1, 0, 19'h30, '0); set1(1, 0, 19'h21, '0); step();
        chk("lastzero_c1_first", m_w, 1);
        set1(0, 0, '0, '0); step();
        set0(0, 0, '0, '0);
        repeat (6) step();
        // Reset two cycles after a read issues
        set0(1, 0, 19'h30, '0); step();
        set0(0, 0, '0, '0); step();
        rst_step();
        repeat (8) step();
        // Random traffic with held requests and occasional abandonment
        pend0 = 0; pend1 = 0;
        for (int i = 0; i < 300; i++) begin
            if (!pend0 && $urandom_range(0, 1) == 1) begin
                set0(1, 1'($urandom), D'($urandom_range(0, 63)), W'($urandom));
                pend0 = 1;
            end else if (pend0 && $urandom_range(0, 15) == 0) begin
                set0(0, 0, '0, '0); pend0 = 0;
            end
            if (!pend1 && $urandom_range(0, 1) == 1) begin
                set1(1, 1'($urandom), D'($urandom_range(0, 63)), W'($urandom));
                pend1 = 1;
            end else if (pend1 && $urandom_range(0, 15) == 0) begin
                set1(0, 0, '0, '0); pend1 = 0;
            end
            step();
            if (m_w == 0) begin set0(0, 0, '0, '0); pend0 = 0; end
            if (m_w == 1) begin set1(0, 0, '0, '0); pend1 = 0; end
        end
        set0(0, 0, '0, '0);
        set1(0, 0, '0, '0);
        repeat (8) step();
        // Spurious valid with an empty tag pipe sets err until reset
        force_v = 1; step();
        force_v = 0;
        repeat (3) step();
        chk("err_sticky", err, 1);
        rst_step();
        step();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
